// File: rtl/i2c_master_top.sv
// i2c_master_top: single-byte I2C write master behind a four-register CPU port.
// Optional STATUS[2]=BUSY is built only when I2C_MASTER_BUSY_STATUS_EN is defined.
module i2c_master_top (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] Addr,
  input  logic [7:0] DataIn,
  input  logic       R_W,
  input  logic       En,
  inout  wire        SDA,
  output logic       SCL,
  output logic [7:0] DataOut
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_STOP
  } state_t;

  state_t     state_q;
  logic       phase_q;
  logic [2:0] bit_q;
  logic [7:0] shift_q;
  logic [7:0] slave_addr_q, tx_data_q, data_out_q;
  logic       done_q, ack_ok_q;
  logic       scl_q, sda_oe_q, sda_o_q;

  logic       wr_d, rd_d, go_d, sda_in;
  logic [7:0] status_d, rd_data_d;

  assign wr_d   = En & ~R_W;
  assign rd_d   = En & R_W;
  assign go_d   = wr_d && (Addr == 2'b10) && DataIn[0];
  assign sda_in = SDA;

  assign SCL     = scl_q;
  assign SDA     = sda_oe_q ? sda_o_q : 1'bz;
  assign DataOut = data_out_q;

`ifdef I2C_MASTER_BUSY_STATUS_EN
  assign status_d = {5'b0, (state_q != S_IDLE), ack_ok_q, done_q};
`else
  assign status_d = {6'b0, ack_ok_q, done_q};
`endif

  always_comb begin
    rd_data_d = 8'h00;
    case (Addr)
      2'b00:   rd_data_d = slave_addr_q;
      2'b01:   rd_data_d = tx_data_q;
      2'b11:   rd_data_d = status_d;
      default: rd_data_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      slave_addr_q <= 8'h00;
      tx_data_q    <= 8'h00;
      data_out_q   <= 8'h00;
    end else begin
      if (wr_d && Addr == 2'b00) slave_addr_q <= DataIn;
      if (wr_d && Addr == 2'b01) tx_data_q    <= DataIn;
      if (rd_d)                  data_out_q   <= rd_data_d;
    end
  end

  // Outputs are registered: each transition loads the SCL/SDA levels of the state being entered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      phase_q  <= 1'b0;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      done_q   <= 1'b0;
      ack_ok_q <= 1'b0;
      scl_q    <= 1'b1;
      sda_oe_q <= 1'b0;
      sda_o_q  <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go_d) begin
            state_q  <= S_START;
            done_q   <= 1'b0;
            ack_ok_q <= 1'b0;
            shift_q  <= {slave_addr_q[6:0], 1'b0};
            scl_q    <= 1'b1;
            sda_oe_q <= 1'b1;
            sda_o_q  <= 1'b0;
          end
        end
        S_START: begin
          state_q <= S_ADDR;
          phase_q <= 1'b0;
          bit_q   <= 3'd7;
          scl_q   <= 1'b0;
          sda_o_q <= shift_q[7];
        end
        S_ADDR, S_DATA: begin
          if (!phase_q) begin
            phase_q <= 1'b1;
            scl_q   <= 1'b1;
          end else if (bit_q == 3'd0) begin
            state_q  <= (state_q == S_ADDR) ? S_ADDR_ACK : S_DATA_ACK;
            phase_q  <= 1'b0;
            scl_q    <= 1'b0;
            sda_oe_q <= 1'b0;
          end else begin
            bit_q   <= bit_q - 3'd1;
            shift_q <= {shift_q[6:0], 1'b0};
            phase_q <= 1'b0;
            scl_q   <= 1'b0;
            sda_o_q <= shift_q[6];
          end
        end
        S_ADDR_ACK: begin
          if (!phase_q) begin
            phase_q <= 1'b1;
            scl_q   <= 1'b1;
          end else if (sda_in == 1'b0) begin
            state_q  <= S_DATA;
            shift_q  <= tx_data_q;
            bit_q    <= 3'd7;
            phase_q  <= 1'b0;
            scl_q    <= 1'b0;
            sda_oe_q <= 1'b1;
            sda_o_q  <= tx_data_q[7];
          end else begin
            state_q  <= S_STOP;
            ack_ok_q <= 1'b0;
            phase_q  <= 1'b0;
            scl_q    <= 1'b0;
            sda_oe_q <= 1'b1;
            sda_o_q  <= 1'b0;
          end
        end
        S_DATA_ACK: begin
          if (!phase_q) begin
            phase_q <= 1'b1;
            scl_q   <= 1'b1;
          end else begin
            ack_ok_q <= (sda_in == 1'b0);
            state_q  <= S_STOP;
            phase_q  <= 1'b0;
            scl_q    <= 1'b0;
            sda_oe_q <= 1'b1;
            sda_o_q  <= 1'b0;
          end
        end
        S_STOP: begin
          if (!phase_q) begin
            phase_q <= 1'b1;
            scl_q   <= 1'b1;
          end else begin
            state_q  <= S_IDLE;
            phase_q  <= 1'b0;
            sda_oe_q <= 1'b0;
            sda_o_q  <= 1'b1;
            done_q   <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_top.sv
// Testbench for i2c_master_top: bus monitor, ACK-driving slave and a bit-sequence reference model.
module tb_i2c_master_top;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] Addr = 2'b00;
  logic [7:0] DataIn = 8'h00;
  logic       R_W = 1'b0;
  logic       En = 1'b0;
  wire        SDA;
  logic       SCL;
  logic [7:0] DataOut;

  logic sl_drv = 1'b0;
  logic sl_val = 1'b1;
  logic slv_ack1 = 1'b0;
  logic slv_ack2 = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   rise_cnt = 0;
  int   base = 0;
  bit   samp [0:2047];

  assign SDA = sl_drv ? sl_val : 1'bz;
  pullup (SDA);

  always #5 clk = ~clk;

  i2c_master_top dut (
    .clk(clk), .reset_n(reset_n), .Addr(Addr), .DataIn(DataIn), .R_W(R_W),
    .En(En), .SDA(SDA), .SCL(SCL), .DataOut(DataOut)
  );

  // Record SDA on every SCL rising edge.
  always @(posedge SCL) begin
    if (rise_cnt < 2048) samp[rise_cnt] = SDA;
    rise_cnt = rise_cnt + 1;
  end

  // Slave answers in the 9th and 18th clock slots of a transfer.
  always @(negedge SCL) begin
    if (rise_cnt - base == 8) begin
      sl_drv = 1'b1;
      sl_val = slv_ack1;
    end else if (rise_cnt - base == 17) begin
      sl_drv = 1'b1;
      sl_val = slv_ack2;
    end else begin
      sl_drv = 1'b0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    Addr = a; DataIn = d; R_W = 1'b0; En = 1'b1;
    @(negedge clk);
    En = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    Addr = a; R_W = 1'b1; En = 1'b1;
    @(negedge clk);
    En = 1'b0; R_W = 1'b0;
    d = DataOut;
  endtask

  task automatic run_xfer(input logic [7:0] addr, input logic [7:0] data, input logic a1,
                          input logic a2, input bit mid_go, input bit mid_upd,
                          input logic [7:0] new_data, input string name);
    bit         exp_q[$];
    logic [7:0] addr_b, data_b, exp_st, st;
    bit         done_seen;
    int         bad, got;
    addr_b = {addr[6:0], 1'b0};
    data_b = mid_upd ? new_data : data;
    for (int i = 7; i >= 0; i--) exp_q.push_back(addr_b[i]);
    exp_q.push_back(a1);
    if (a1 == 1'b0) begin
      for (int i = 7; i >= 0; i--) exp_q.push_back(data_b[i]);
      exp_q.push_back(a2);
    end
    exp_q.push_back(1'b0);
    exp_st = {6'b0, (a1 == 1'b0 && a2 == 1'b0), 1'b1};

    cpu_write(2'b00, addr);
    cpu_write(2'b01, data);
    slv_ack1 = a1;
    slv_ack2 = a2;
    base = rise_cnt;
    cpu_write(2'b10, 8'h01);
    n_tests++;
    if (SCL !== 1'b1 || SDA !== 1'b0) begin
      n_fail++;
      $display("FAIL %s start: SCL=%b SDA=%b, required SCL=1 SDA=0", name, SCL, SDA);
    end
    if (mid_go || mid_upd) begin
      repeat (3) @(negedge clk);
      if (mid_go) cpu_write(2'b10, 8'h01);
      if (mid_upd) begin
        cpu_write(2'b00, ~addr);
        cpu_write(2'b01, new_data);
      end
    end
    done_seen = 1'b0;
    st = 8'h00;
    for (int k = 0; k < 100 && !done_seen; k++) begin
      cpu_read(2'b11, st);
      if (st[0]) done_seen = 1'b1;
    end
    n_tests++;
    if (!done_seen) begin
      n_fail++;
      $display("FAIL %s done: DONE never set, last STATUS=%02h", name, st);
    end
    repeat (4) @(negedge clk);
    got = rise_cnt - base;
    n_tests++;
    if (got != int'(exp_q.size())) begin
      n_fail++;
      $display("FAIL %s edges: %0d SCL rises, required %0d", name, got, exp_q.size());
    end
    bad = 0;
    for (int i = 0; i < int'(exp_q.size()) && i < got; i++)
      if (samp[base + i] !== exp_q[i]) bad++;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s bits: %0d sampled bits differ (addr %02h data %02h)", name, bad, addr_b, data_b);
    end
    n_tests++;
    if (st !== exp_st) begin
      n_fail++;
      $display("FAIL %s status: got %02h, required %02h", name, st, exp_st);
    end
    n_tests++;
    if (SCL !== 1'b1 || SDA !== 1'b1) begin
      n_fail++;
      $display("FAIL %s idle: SCL=%b SDA=%b, required SCL=1 SDA released", name, SCL, SDA);
    end
  endtask

  task automatic test_reset;
    logic [7:0] d;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (SCL !== 1'b1 || SDA !== 1'b1 || DataOut !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: SCL=%b SDA=%b DataOut=%02h, required 1 1 00", SCL, SDA, DataOut);
    end
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      cpu_read(2'(a), d);
      n_tests++;
      if (d !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_reg%0d: got %02h, required 00", a, d);
      end
    end
  endtask

  task automatic test_readback;
    logic [7:0] d, v;
    cpu_write(2'b01, 8'h5A);
    cpu_read(2'b01, d);
    n_tests++;
    if (d !== 8'h5A) begin
      n_fail++;
      $display("FAIL readback_tx: got %02h, required 5a", d);
    end
    for (int i = 0; i < 3; i++) begin
      v = 8'($urandom);
      cpu_write(2'(i & 1), v);
      cpu_read(2'(i & 1), d);
      n_tests++;
      if (d !== v) begin
        n_fail++;
        $display("FAIL readback_rand%0d: got %02h, required %02h", i, d, v);
      end
    end
  endtask

  task automatic test_addr_nack;
    run_xfer(8'hE3, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "addr_nack");
  endtask

  task automatic test_success;
    run_xfer(8'hE3, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "success");
  endtask

  task automatic test_data_nack;
    run_xfer(8'($urandom), 8'($urandom), 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "data_nack");
  endtask

  task automatic test_go_ignored;
    run_xfer(8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "go_ignored");
  endtask

  task automatic test_reg_update;
    run_xfer(8'($urandom), 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 8'($urandom), "reg_update");
  endtask

  task automatic test_random;
    for (int i = 0; i < 6; i++)
      run_xfer(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'b0, 1'b0, 8'h00, "random");
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    int         r0;
    cpu_write(2'b00, 8'hA5);
    cpu_write(2'b01, 8'h3C);
    cpu_read(2'b01, d);
    slv_ack1 = 1'b0;
    slv_ack2 = 1'b0;
    base = rise_cnt;
    cpu_write(2'b10, 8'h01);
    repeat (6) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if (SCL !== 1'b1 || SDA !== 1'b1 || DataOut !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid: SCL=%b SDA=%b DataOut=%02h, required 1 1 00", SCL, SDA, DataOut);
    end
    r0 = rise_cnt;
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    n_tests++;
    if (rise_cnt != r0 || SCL !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: %0d SCL rises after reset, SCL=%b, required 0 and 1", rise_cnt - r0, SCL);
    end
    cpu_read(2'b11, d);
    n_tests++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid_status: got %02h, required 00", d);
    end
    cpu_read(2'b01, d);
    n_tests++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid_tx: got %02h, required 00", d);
    end
  endtask

  initial begin
    test_reset();
    test_readback();
    test_addr_nack();
    test_success();
    test_data_nack();
    test_go_ignored();
    test_reg_update();
    test_random();
    test_reset_mid();
    test_success();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
